// File: rtl/alu_exec_sequencer_pkg.sv
// Shared definitions for the 4-bit ALU execution sequencer: widths, opcodes,
// instruction layout and controller state encoding.
package alu_exec_sequencer_pkg;

    localparam int DATA_W  = 4;
    localparam int REG_CNT = 4;
    localparam int ADDR_W  = 2;
    localparam int INSTR_W = 9;

    localparam int OP_HI = 8;
    localparam int OP_LO = 6;
    localparam int RS_HI = 5;
    localparam int RS_LO = 4;
    localparam int RT_HI = 3;
    localparam int RT_LO = 2;
    localparam int RD_HI = 1;
    localparam int RD_LO = 0;

    typedef enum logic [2:0] {
        OP_SUB    = 3'd0,
        OP_ADD    = 3'd1,
        OP_OR     = 3'd2,
        OP_AND    = 3'd3,
        OP_RSHIFT = 3'd4,
        OP_LSHIFT = 3'd5,
        OP_LT     = 3'd6,
        OP_EQ     = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } seq_state_e;

    typedef struct packed {
        alu_op_e           op;
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
        logic [ADDR_W-1:0] rd;
    } instr_t;

    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
        instr_t f;
        f.op = alu_op_e'(raw[OP_HI:OP_LO]);
        f.rs = raw[RS_HI:RS_LO];
        f.rt = raw[RT_HI:RT_LO];
        f.rd = raw[RD_HI:RD_LO];
        return f;
    endfunction

endpackage

// File: rtl/alu_4bit.sv
// Purely combinational 4-bit ALU; shared by the sequencer and the display top.
module alu_4bit
    import alu_exec_sequencer_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    // Opcode decode; compare ops carry a fixed marker pattern in the upper bits.
    always_comb begin
        y = 4'd0;
        case (alu_op_e'(op))
            OP_SUB:    y = a + ~b + 4'd1;
            OP_ADD:    y = a + b;
            OP_OR:     y = a | b;
            OP_AND:    y = a & b;
            OP_RSHIFT: y = {b[3], b[3:1]};
            OP_LSHIFT: y = {a[2:0], a[3]};
            OP_LT:     y = {3'b101, (a < b)};
            OP_EQ:     y = {3'b111, (a == b)};
            default:   y = 4'd0;
        endcase
    end

endmodule

// File: rtl/alu_exec_sequencer.sv
// Four-state controller that reads two registers, runs the ALU and writes the
// result back; owns the 4x4 register file.
module alu_exec_sequencer
    import alu_exec_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_en,
    input  logic [1:0] load_addr,
    input  logic [3:0] load_data,
    input  logic       instr_valid,
    input  logic [8:0] instr,
    output logic       instr_ready,
    output logic       busy,
    output logic       done,
    output logic [3:0] result,
    input  logic [1:0] dbg_addr,
    output logic [3:0] dbg_data,
    output logic [7:0] instr_count
);

    seq_state_e        state_q, state_d;
    instr_t            instr_q, instr_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] r_q, r_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] regs_q [REG_CNT];
    logic [DATA_W-1:0] regs_d [REG_CNT];
    logic [DATA_W-1:0] alu_y_s;

    alu_4bit u_alu (
        .op (instr_q.op),
        .a  (a_q),
        .b  (b_q),
        .y  (alu_y_s)
    );

    // Next-state and datapath update; load only lands while idle and wins over an instruction.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        regs_d   = regs_q;
        case (state_q)
            IDLE: begin
                if (load_en) begin
                    regs_d[load_addr] = load_data;
                end else if (instr_valid) begin
                    instr_d = decode_instr(instr);
                    state_d = DECODE;
                end else begin
                    state_d = IDLE;
                end
            end
            DECODE: begin
                a_d     = regs_q[instr_q.rs];
                b_d     = regs_q[instr_q.rt];
                state_d = EXEC;
            end
            EXEC: begin
                r_d     = alu_y_s;
                state_d = WB;
            end
            WB: begin
                regs_d[instr_q.rd] = r_q;
                result_d           = r_q;
                cnt_d              = cnt_q + 8'd1;
                state_d            = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_d = (state_d == WB);
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            instr_q  <= '{op: OP_SUB, rs: 2'd0, rt: 2'd0, rd: 2'd0};
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            r_q      <= 4'd0;
            result_q <= 4'd0;
            cnt_q    <= 8'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            for (int i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= 4'd0;
            end
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            regs_q   <= regs_d;
        end
    end

    assign instr_ready = (state_q == IDLE) & ~load_en;
    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign instr_count = cnt_q;
    assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Randomised scoreboard bench for alu_exec_sequencer with a high-level reference model.
module tb_alu_exec_sequencer;

    logic       clk;
    logic       rst;
    logic       load_en;
    logic [1:0] load_addr;
    logic [3:0] load_data;
    logic       instr_valid;
    logic [8:0] instr;
    logic       instr_ready;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;
    logic [7:0] instr_count;

    alu_exec_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .instr_count (instr_count)
    );

    typedef struct {
        logic [1:0] rd;
        int         val;
        int         cnt;
        int         hs;
        int         prev_hs;
        bit         b2b;
    } exp_t;

    exp_t sb[$];
    int   m_regs[4];
    int   m_cnt;
    int   last_hs;
    bit   prev_keep;
    int   cyc = 0;
    int   n_tot = 0;
    int   n_bad = 0;
    bit   rchk_req = 1'b0;
    bit   end_chk = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    function automatic int ref_alu(input int op, input int a, input int b);
        int sb_v;
        case (op)
            0: return (a - b + 16) % 16;
            1: return (a + b) % 16;
            2: return a | b;
            3: return a & b;
            4: begin
                sb_v = (b >= 8) ? b - 16 : b;
                return (sb_v >>> 1) & 15;
            end
            5: return (a * 2 + a / 8) % 16;
            6: return 10 + ((a < b) ? 1 : 0);
            7: return 14 + ((a == b) ? 1 : 0);
            default: return 0;
        endcase
    endfunction

    function automatic logic [8:0] mk(input int op, input int rs, input int rt, input int rd);
        return {3'(op), 2'(rs), 2'(rt), 2'(rd)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    task automatic reset_dut(input int hold);
        rst = 1'b1;
        repeat (hold) tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        m_cnt     = 0;
        prev_keep = 1'b0;
        sb.delete();
        rchk_req = 1'b1;
        repeat (6) tick();
        rchk_req = 1'b0;
    endtask

    task automatic load(input int a, input int d, input bit honoured);
        load_en   = 1'b1;
        load_addr = 2'(a);
        load_data = 4'(d);
        tick();
        load_en = 1'b0;
        if (honoured) m_regs[a] = d;
    endtask

    task automatic issue(input logic [8:0] ins, input bit keep);
        exp_t e;
        int   k;
        instr       = ins;
        instr_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!instr_ready && k < 20);
        if (!instr_ready) begin
            $display("FAIL handshake_timeout: instr_ready=%0d after %0d cycles, required 1", instr_ready, k);
            $fatal(1, "handshake timeout");
        end
        e.val     = ref_alu(int'(ins[8:6]), m_regs[ins[5:4]], m_regs[ins[3:2]]);
        e.rd      = ins[1:0];
        m_cnt     = (m_cnt + 1) % 256;
        e.cnt     = m_cnt;
        e.hs      = cyc;
        e.prev_hs = last_hs;
        e.b2b     = prev_keep;
        last_hs   = cyc;
        prev_keep = keep;
        sb.push_back(e);
        m_regs[ins[1:0]] = e.val;
        tick();
        if (!keep) instr_valid = 1'b0;
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        n_tot++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse and checks the writeback.
    initial begin
        exp_t cur;
        bit   wb_pend  = 1'b0;
        bit   end_done = 1'b0;
        int   ridx     = 0;
        dbg_addr = 2'd0;
        forever begin
            @(negedge clk);
            if (wb_pend) begin
                wb_pend = 1'b0;
                chk("wb_result", int'(result), cur.val);
                chk("wb_regfile", int'(dbg_data), cur.val);
                chk("wb_count", int'(instr_count), cur.cnt);
                chk("idle_after_wb", int'(busy), 0);
            end
            if (rchk_req) begin
                if (ridx == 0) begin
                    chk("rst_busy", int'(busy), 0);
                    chk("rst_done", int'(done), 0);
                    chk("rst_result", int'(result), 0);
                    chk("rst_count", int'(instr_count), 0);
                    chk("rst_ready", int'(instr_ready), 1);
                end else if (ridx <= 4) begin
                    chk("rst_reg", int'(dbg_data), 0);
                end
                if (ridx < 4) dbg_addr = 2'(ridx);
                ridx++;
            end else begin
                ridx = 0;
            end
            if (load_en) chk("ready_with_load", int'(instr_ready), 0);
            if (busy) chk("ready_while_busy", int'(instr_ready), 0);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    cur = sb.pop_front();
                    chk("latency", cyc - cur.hs, 3);
                    if (cur.b2b) chk("b2b_spacing", cur.hs - cur.prev_hs, 4);
                    dbg_addr = cur.rd;
                    wb_pend  = 1'b1;
                end
            end
            if (end_chk && !end_done) begin
                end_done = 1'b1;
                chk("scoreboard_drained", sb.size(), 0);
            end
        end
    end

    // Stimulus: directed test plan, hazard/priority cases, mid-op reset, then random traffic.
    initial begin
        bit keep;
        rst         = 1'b1;
        load_en     = 1'b0;
        load_addr   = 2'd0;
        load_data   = 4'd0;
        instr_valid = 1'b0;
        instr       = 9'd0;
        last_hs     = 0;
        prev_keep   = 1'b0;
        reset_dut(2);

        load(0, 3, 1'b1);
        load(1, 5, 1'b1);
        issue(mk(1, 0, 1, 2), 1'b0); settle();
        issue(mk(0, 0, 1, 3), 1'b0); settle();
        issue(mk(6, 0, 1, 2), 1'b0); settle();
        issue(mk(7, 0, 0, 2), 1'b0); settle();
        issue(mk(7, 0, 1, 2), 1'b0); settle();

        load(1, 9, 1'b1);
        issue(mk(4, 0, 1, 2), 1'b0); settle();
        issue(mk(5, 1, 0, 2), 1'b0); settle();
        load(0, 7, 1'b1);
        issue(mk(2, 0, 1, 2), 1'b0); settle();
        issue(mk(3, 0, 1, 3), 1'b0); settle();
        issue(mk(1, 1, 1, 2), 1'b0); settle();

        load(0, 6, 1'b1);
        issue(mk(1, 0, 0, 0), 1'b0); settle();
        issue(mk(1, 0, 0, 1), 1'b0); settle();

        issue(mk(1, 0, 1, 2), 1'b1);
        issue(mk(0, 2, 1, 3), 1'b1);
        issue(mk(2, 3, 3, 0), 1'b0); settle();

        // load and instruction together: load lands first, instruction waits a cycle
        load_en     = 1'b1;
        load_addr   = 2'd2;
        load_data   = 4'd11;
        instr       = mk(1, 2, 0, 3);
        instr_valid = 1'b1;
        m_regs[2]   = 11;
        tick();
        load_en = 1'b0;
        issue(mk(1, 2, 0, 3), 1'b0);
        load(1, 13, 1'b0);
        settle();
        issue(mk(1, 1, 1, 0), 1'b0); settle();

        issue(mk(1, 1, 1, 3), 1'b0);
        tick();
        reset_dut(1);
        issue(mk(1, 3, 3, 2), 1'b0); settle();

        reset_dut(2);
        for (int n = 0; n < 300; n++) begin
            if (!prev_keep && ($urandom % 4 == 0)) begin
                load(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 1'b1);
            end
            keep = (n != 299) && ($urandom % 3 == 0);
            issue(9'($urandom_range(0, 511)), keep);
            if (!keep) settle();
        end

        repeat (4) tick();
        end_chk = 1'b1;
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_sequencer.md
Name: alu_exec_sequencer

Overview:
- Multi-cycle controller that sequences the 4-bit decode-and-execute ALU datapath.
- Owns a 4-entry x 4-bit register file.
- Accepts one instruction per valid/ready handshake. Reads rs/rt from the register file, drives the ALU with the opcode, then writes the result back to rd.
- Sits between an instruction source (switch/button front end or testbench) and the 7-segment display path.

Parameters:
- DATA_W, 4, operand/result width; fixed at 4 and not re-sized.
- REG_CNT, 4, register file depth; register address width = 2.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- load_en  input  1  direct register-file write request (initialisation)
- load_addr  input  2  register index for load
- load_data  input  4  value for load
- instr_valid  input  1  instruction present
- instr  input  9  {op[8:6], rs[5:4], rt[3:2], rd[1:0]}
- instr_ready  output  1  instruction accepted this cycle when valid & ready
- busy  output  1  FSM not in IDLE
- done  output  1  one-cycle pulse on writeback
- result  output  4  last written-back value (feeds display)
- dbg_addr  input  2  debug read address
- dbg_data  output  4  combinational register-file read of dbg_addr
- instr_count  output  8  completed instructions, wraps 255->0

Behaviour:
- Reset: FSM=IDLE; all registers=0; result=0; done=0; instr_count=0; instr_ready=1 in the following cycle unless load_en is high.
- Reset mid-operation abandons the instruction with no writeback and no done pulse.
- instr_ready = (state==IDLE) & ~load_en. Load takes priority over an instruction in the same cycle, and the instruction is held off.
- load_en is honoured only in IDLE: reg[load_addr] <= load_data. It is ignored while busy.
- FSM states:
  - IDLE -> DECODE on valid&ready. The instruction fields are latched.
  - DECODE: latch A=reg[rs], B=reg[rt]; -> EXEC.
  - EXEC: latch R=alu(op,A,B); -> WB.
  - WB: reg[rd] <= R, result <= R, done=1, instr_count++; -> IDLE.
- Latency: handshake in cycle N; done high and the register updated at the end of cycle N+3. Throughput is 1 instruction per 4 cycles.
- Operands are sampled in DECODE, so rs==rd or rt==rd read the pre-write value.
- ALU op encoding (unsigned, modulo 16):
  - 0 SUB: A-B (A + ~B + 1, carry dropped)
  - 1 ADD: A+B, carry dropped
  - 2 OR: A|B
  - 3 AND: A&B
  - 4 RSHIFT: arithmetic right shift of B by 1, {B[3],B[3:1]}
  - 5 LSHIFT: rotate-left of A by 1, {A[2:0],A[3]}
  - 6 LT: {1,0,1,(A<B)}
  - 7 EQ: {1,1,1,(A==B)}
- instr_valid while busy is ignored; the source must hold it until instr_ready.
- dbg_data reflects register contents after the clock edge (write-first not required).

Decomposition:
- Shared package:
  - opcode constants OP_SUB..OP_EQ (3 bits)
  - instruction field positions
  - FSM state encoding: IDLE=0, DECODE=1, EXEC=2, WB=3
- One sub-module, alu_4bit: purely combinational, (op, a, b) -> y, implementing the table above. It is instantiated once by the sequencer and is reusable by the display top level.

Test Plan:
- Reset then load r0=3, r1=5. Issue ADD rd=r2 {001,00,01,10} -> done 3 cycles after handshake, dbg r2=8, result=8, instr_count=1.
- SUB r0-r1 into r3 (3-5) -> r3=4'hE. Then LT r0,r1 -> 4'b1011. EQ r0,r0 -> 4'b1111. EQ r0,r1 -> 4'b1110.
- r1=4'b1001: RSHIFT rt=r1 -> 4'b1100. LSHIFT rs=r1 -> 4'b0011. r0=7 OR/AND with r1=9 -> 4'hF / 4'h1. ADD 9+9 -> 2 (wrap).
- Hazard: ADD r0,r0 -> r0 with r0=6 -> r0=12. Back-to-back valid held high -> second instr_ready only after return to IDLE, exactly 4-cycle spacing.
- Simultaneous load_en and instr_valid in IDLE -> load writes, instr_ready=0 that cycle, instruction accepted next cycle. load_en while busy -> register unchanged.
- Assert rst during EXEC -> no done pulse, rd unchanged (=0), instr_count=0. Also run 256 instructions -> instr_count wraps to 0.
